// File: rtl/display_pkg.sv
// display_pkg: mode encodings and active-low g..a glyphs shared by the scanned display controller.
package display_pkg;
    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_SCROLL = 2'b01,
        MODE_BLANK  = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low segments; without select only 0-9 light up.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       select,
    output logic [6:0] seg
);
    assign seg = (select || nibble < 4'd10) ? HEX_GLYPH[nibble] : SEG_BLANK;
endmodule

// File: rtl/scan_display_ctrl.sv
// scan_display_ctrl: multiplexed 7-segment scanner showing a static or scrolling window of a nibble string.
module scan_display_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TEXT_NIBBLES = 16,
    parameter int SCAN_DIV     = 100000,
    parameter int SCROLL_DIV   = 50000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [4*TEXT_NIBBLES-1:0]       text,
    input  logic [1:0]                      mode,
    input  logic [$clog2(TEXT_NIBBLES)-1:0] win_sel,
    input  logic                            select,
    output logic [6:0]                      OUT,
    output logic [NUM_DIGITS-1:0]           EN
);
    localparam int PW = $clog2(TEXT_NIBBLES);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(SCROLL_DIV);
    localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] SCROLL_LAST = RW'(SCROLL_DIV - 1);
    localparam logic [DW-1:0] D_LAST      = DW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PTR_LAST    = PW'(TEXT_NIBBLES - 1);
    localparam logic [PW:0]   TN_W        = (PW + 1)'(TEXT_NIBBLES);

    mode_e         md;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [RW-1:0] scroll_cnt_q, scroll_cnt_d;
    logic [DW-1:0] d_q, d_d;
    logic [PW-1:0] ptr_q, ptr_d, ptr_ws, ptr_inc, idx;
    logic          pending_q, pending_d;
    logic          scan_tick, frame, scroll_tick, step;
    logic [PW:0]   sum;
    logic [3:0]    nibs [TEXT_NIBBLES];
    logic [3:0]    nib;
    logic [6:0]    seg;

    for (genvar i = 0; i < TEXT_NIBBLES; i++) begin : g_nib
        assign nibs[i] = text[4*i +: 4];
    end

    // Outputs are registered from next-state d/ptr so a new digit appears the cycle after its scan_tick.
    always_comb begin
        md           = mode_e'(mode);
        scan_tick    = scan_cnt_q == SCAN_LAST;
        frame        = scan_tick && d_q == D_LAST;
        scan_cnt_d   = scan_tick ? '0 : scan_cnt_q + 1'b1;
        d_d          = !scan_tick ? d_q : frame ? '0 : d_q + 1'b1;
        scroll_tick  = md == MODE_SCROLL && scroll_cnt_q == SCROLL_LAST;
        scroll_cnt_d = (md != MODE_SCROLL || scroll_tick) ? '0 : scroll_cnt_q + 1'b1;
        step         = pending_q || scroll_tick;
        pending_d    = md == MODE_SCROLL && step && !frame;
        ptr_ws       = ({1'b0, win_sel} >= TN_W) ? PW'({1'b0, win_sel} - TN_W) : win_sel;
        ptr_inc      = ptr_q == PTR_LAST ? '0 : ptr_q + 1'b1;
        ptr_d        = !frame ? ptr_q :
                       md == MODE_STATIC ? ptr_ws :
                       (md == MODE_SCROLL && step) ? ptr_inc : ptr_q;
        sum          = {1'b0, ptr_d} + (PW + 1)'(d_d);
        idx          = PW'(sum >= TN_W ? sum - TN_W : sum);
        nib          = nibs[idx];
    end

    seg7_decode u_dec (
        .nibble (nib),
        .select (select),
        .seg    (seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q   <= '0;
            scroll_cnt_q <= '0;
            d_q          <= '0;
            ptr_q        <= '0;
            pending_q    <= 1'b0;
            EN           <= '1;
            OUT          <= SEG_BLANK;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            scroll_cnt_q <= scroll_cnt_d;
            d_q          <= d_d;
            ptr_q        <= ptr_d;
            pending_q    <= pending_d;
            EN           <= md == MODE_BLANK ? '1 : ~(NUM_DIGITS'(1) << d_d);
            OUT          <= md == MODE_BLANK ? SEG_BLANK : seg;
        end
    end
endmodule

// File: tb/tb_scan_display_ctrl.sv
// tb_scan_display_ctrl: scoreboard bench sampling each digit slot one cycle after its start edge.
module tb_scan_display_ctrl;
    localparam int ND  = 4;
    localparam int TN  = 16;
    localparam int SD  = 4;
    localparam int SRD = 40;

    typedef struct packed {
        logic [3:0] en;
        logic [6:0] out;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] text = 64'hFEDCBA9876543210;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  win_sel = 4'd0;
    logic        select = 1'b1;
    logic [6:0]  OUT;
    logic [3:0]  EN;
    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cur_d = 0;

    scan_display_ctrl #(
        .NUM_DIGITS   (ND),
        .TEXT_NIBBLES (TN),
        .SCAN_DIV     (SD),
        .SCROLL_DIV   (SRD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .text    (text),
        .mode    (mode),
        .win_sel (win_sel),
        .select  (select),
        .OUT     (OUT),
        .EN      (EN)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout want summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] glyph(input int nib, input logic hex);
        if (!hex && nib > 9) return 7'h7F;
        case (nib)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic int nib_at(input int i);
        return int'(text[4*(i % TN) +: 4]);
    endfunction

    task automatic push_digit(input int d, input int p);
        logic [3:0] en;
        en = 4'b0001 << d;
        sb.push_back('{en: ~en, out: glyph(nib_at(p + d), select)});
    endtask

    task automatic push_frame(input int p);
        for (int d = 0; d < ND; d++) push_digit(d, p);
    endtask

    task automatic next_slot;
        repeat (SD) @(posedge clk);
        @(negedge clk);
        cur_d = (cur_d + 1) % ND;
    endtask

    task automatic skip_frame;
        repeat (ND) next_slot();
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests += 2;
        if (EN !== 4'hF) begin n_fail++; $display("FAIL reset_en: got %b want 1111", EN); end
        if (OUT !== 7'h7F) begin n_fail++; $display("FAIL reset_out: got %h want 7f", OUT); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cur_d = 0;
    endtask

    task automatic test_static;
        exp_t e;
        for (int f = 0; f < 2; f++) push_frame(0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests += 2;
            if (EN !== e.en) begin n_fail++; $display("FAIL static_en d=%0d: got %b want %b", cur_d, EN, e.en); end
            if (OUT !== e.out) begin n_fail++; $display("FAIL static_out d=%0d: got %h want %h", cur_d, OUT, e.out); end
            next_slot();
        end
    endtask

    task automatic test_wrap;
        exp_t e;
        win_sel = 4'd14;
        push_frame(0);
        push_frame(14);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests += 2;
            if (EN !== e.en) begin n_fail++; $display("FAIL wrap_en d=%0d: got %b want %b", cur_d, EN, e.en); end
            if (OUT !== e.out) begin n_fail++; $display("FAIL wrap_out d=%0d: got %h want %h", cur_d, OUT, e.out); end
            next_slot();
        end
    endtask

    task automatic test_decimal;
        exp_t e;
        select = 1'b0;
        win_sel = 4'd10;
        skip_frame();
        win_sel = 4'd8;
        push_frame(10);
        push_frame(8);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests += 2;
            if (EN !== e.en) begin n_fail++; $display("FAIL dec_en d=%0d: got %b want %b", cur_d, EN, e.en); end
            if (OUT !== e.out) begin n_fail++; $display("FAIL dec_out d=%0d: got %h want %h", cur_d, OUT, e.out); end
            next_slot();
        end
    endtask

    task automatic test_scroll;
        exp_t e;
        select = 1'b1;
        win_sel = 4'd0;
        skip_frame();
        mode = 2'b01;
        // Scroll ticks land on frame cycle 40n; frame f starts at cycle 16f after 16f-1 has been seen.
        for (int f = 0; f < 42; f++) push_frame(f == 0 ? 0 : ((16 * f - 1) / SRD) % TN);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests += 2;
            if (EN !== e.en) begin n_fail++; $display("FAIL scroll_en d=%0d: got %b want %b", cur_d, EN, e.en); end
            if (OUT !== e.out) begin n_fail++; $display("FAIL scroll_out d=%0d: got %h want %h", cur_d, OUT, e.out); end
            next_slot();
        end
    endtask

    task automatic test_freeze;
        exp_t e;
        mode = 2'b11;
        win_sel = 4'd5;
        for (int f = 0; f < 4; f++) push_frame(0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests += 2;
            if (EN !== e.en) begin n_fail++; $display("FAIL freeze_en d=%0d: got %b want %b", cur_d, EN, e.en); end
            if (OUT !== e.out) begin n_fail++; $display("FAIL freeze_out d=%0d: got %h want %h", cur_d, OUT, e.out); end
            next_slot();
        end
    endtask

    task automatic test_blank;
        exp_t e;
        mode = 2'b00;
        skip_frame();
        push_digit(0, 5);
        push_digit(1, 5);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests += 2;
            if (EN !== e.en) begin n_fail++; $display("FAIL preblank_en d=%0d: got %b want %b", cur_d, EN, e.en); end
            if (OUT !== e.out) begin n_fail++; $display("FAIL preblank_out d=%0d: got %h want %h", cur_d, OUT, e.out); end
            next_slot();
        end
        mode = 2'b10;
        win_sel = 4'd9;
        @(posedge clk);
        @(negedge clk);
        n_tests += 2;
        if (EN !== 4'hF) begin n_fail++; $display("FAIL blank_en_now: got %b want 1111", EN); end
        if (OUT !== 7'h7F) begin n_fail++; $display("FAIL blank_out_now: got %h want 7f", OUT); end
        repeat (SD - 1) @(posedge clk);
        @(negedge clk);
        cur_d = 3;
        repeat (2) sb.push_back('{en: 4'hF, out: 7'h7F});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests += 2;
            if (EN !== e.en) begin n_fail++; $display("FAIL blank_en d=%0d: got %b want %b", cur_d, EN, e.en); end
            if (OUT !== e.out) begin n_fail++; $display("FAIL blank_out d=%0d: got %h want %h", cur_d, OUT, e.out); end
            next_slot();
        end
        mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
        n_tests += 2;
        if (EN !== 4'b1101) begin n_fail++; $display("FAIL resume_en: got %b want 1101", EN); end
        if (OUT !== glyph(6, 1'b1)) begin n_fail++; $display("FAIL resume_out: got %h want %h", OUT, glyph(6, 1'b1)); end
        repeat (SD - 1) @(posedge clk);
        @(negedge clk);
        cur_d = 2;
        push_digit(2, 5);
        push_digit(3, 5);
        push_frame(9);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests += 2;
            if (EN !== e.en) begin n_fail++; $display("FAIL postblank_en d=%0d: got %b want %b", cur_d, EN, e.en); end
            if (OUT !== e.out) begin n_fail++; $display("FAIL postblank_out d=%0d: got %h want %h", cur_d, OUT, e.out); end
            next_slot();
        end
    endtask

    task automatic test_reset_mid;
        win_sel = 4'd5;
        skip_frame();
        next_slot();
        next_slot();
        n_tests += 2;
        if (EN !== 4'b1011) begin n_fail++; $display("FAIL prerst_en: got %b want 1011", EN); end
        if (OUT !== glyph(7, 1'b1)) begin n_fail++; $display("FAIL prerst_out: got %h want %h", OUT, glyph(7, 1'b1)); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests += 2;
        if (EN !== 4'hF) begin n_fail++; $display("FAIL midrst_en: got %b want 1111", EN); end
        if (OUT !== 7'h7F) begin n_fail++; $display("FAIL midrst_out: got %h want 7f", OUT); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests += 2;
        if (EN !== 4'b1110) begin n_fail++; $display("FAIL rel_en: got %b want 1110", EN); end
        if (OUT !== glyph(0, 1'b1)) begin n_fail++; $display("FAIL rel_out: got %h want %h", OUT, glyph(0, 1'b1)); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (EN !== 4'b1110) begin n_fail++; $display("FAIL pretick_en: got %b want 1110", EN); end
        @(posedge clk);
        @(negedge clk);
        n_tests += 2;
        if (EN !== 4'b1101) begin n_fail++; $display("FAIL firsttick_en: got %b want 1101", EN); end
        if (OUT !== glyph(1, 1'b1)) begin n_fail++; $display("FAIL firsttick_out: got %h want %h", OUT, glyph(1, 1'b1)); end
    endtask

    initial begin
        test_reset();
        test_static();
        test_wrap();
        test_decimal();
        test_scroll();
        test_freeze();
        test_blank();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
